// File: rtl/tl_handshake_monitor.sv
// Per-channel request/response handshake checker: in-flight counting, payload stability,
// optional stall timeout (enable with TL_HANDSHAKE_MONITOR_TIMEOUT_EN).
module tl_handshake_monitor #(
    parameter int unsigned CHANNELS        = 2,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned TIMEOUT         = 255,
    localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       a_valid,
    input  logic [CHANNELS-1:0]       a_ready,
    input  logic [CHANNELS*DATA_W-1:0] a_data,
    input  logic [CHANNELS-1:0]       d_valid,
    input  logic [CHANNELS-1:0]       d_ready,
    output logic [CHANNELS-1:0]       err_stable,
    output logic [CHANNELS-1:0]       err_overflow,
    output logic [CHANNELS-1:0]       err_underflow,
    output logic [CHANNELS-1:0]       err_timeout,
    output logic                      err_any,
    output logic [CHANNELS*CNT_W-1:0] outstanding
);

    logic [CNT_W-1:0]  cnt_q  [CHANNELS];
    logic [CNT_W-1:0]  cnt_d  [CHANNELS];
    logic [DATA_W-1:0] data_q [CHANNELS];
    logic [DATA_W-1:0] data_d [CHANNELS];
    logic [CHANNELS-1:0] stall_q, stall_d;
    logic [CHANNELS-1:0] stable_q, stable_d;
    logic [CHANNELS-1:0] over_q, over_d;
    logic [CHANNELS-1:0] under_q, under_d;
    logic [CHANNELS-1:0] timeout_q;
    logic                err_any_q, err_any_d;

    always_comb begin
        stall_d  = stall_q;
        stable_d = '0;
        over_d   = '0;
        under_d  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i]  = cnt_q[i];
            data_d[i] = data_q[i];
            if (a_valid[i] && a_ready[i] && !(d_valid[i] && d_ready[i])) begin
                if (cnt_q[i] == CNT_W'(MAX_OUTSTANDING)) over_d[i] = 1'b1;
                else                                      cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (d_valid[i] && d_ready[i] && !(a_valid[i] && a_ready[i])) begin
                if (cnt_q[i] == '0) under_d[i] = 1'b1;
                else                cnt_d[i]   = cnt_q[i] - 1'b1;
            end
            if (stall_q[i] && (!a_valid[i] || a_data[i*DATA_W +: DATA_W] != data_q[i])) begin
                stable_d[i] = 1'b1;
            end
            // Recapture on every stalled edge so one payload change reports exactly once.
            if (a_valid[i] && !a_ready[i]) begin
                stall_d[i] = 1'b1;
                data_d[i]  = a_data[i*DATA_W +: DATA_W];
            end else begin
                stall_d[i] = 1'b0;
            end
        end
        err_any_d = err_any_q | (|stable_q) | (|over_q) | (|under_q) | (|timeout_q);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i]  <= '0;
                data_q[i] <= '0;
            end
            stall_q   <= '0;
            stable_q  <= '0;
            over_q    <= '0;
            under_q   <= '0;
            err_any_q <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i]  <= cnt_d[i];
                data_q[i] <= data_d[i];
            end
            stall_q   <= stall_d;
            stable_q  <= stable_d;
            over_q    <= over_d;
            under_q   <= under_d;
            err_any_q <= err_any_d;
        end
    end

`ifdef TL_HANDSHAKE_MONITOR_TIMEOUT_EN
    logic [15:0]         to_q [CHANNELS];
    logic [15:0]         to_d [CHANNELS];
    logic [CHANNELS-1:0] timeout_d;

    // Counter saturates at the limit so a long stall reports only once.
    always_comb begin
        timeout_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            to_d[i] = to_q[i];
            if (a_valid[i] && !a_ready[i]) begin
                if (to_q[i] != 16'(TIMEOUT)) begin
                    to_d[i] = to_q[i] + 16'd1;
                    if (to_q[i] + 16'd1 == 16'(TIMEOUT)) timeout_d[i] = 1'b1;
                end
            end else begin
                to_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) to_q[i] <= '0;
            timeout_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) to_q[i] <= to_d[i];
            timeout_q <= timeout_d;
        end
    end
`else
    assign timeout_q = '0;
`endif

    always_comb begin
        outstanding = '0;
        for (int i = 0; i < CHANNELS; i++) outstanding[i*CNT_W +: CNT_W] = cnt_q[i];
    end

    assign err_stable    = stable_q;
    assign err_overflow  = over_q;
    assign err_underflow = under_q;
    assign err_timeout   = timeout_q;
    assign err_any       = err_any_q;

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (stable_q[i])  $display("tl_handshake_monitor: ch%0d stable error", i);
            if (over_q[i])    $display("tl_handshake_monitor: ch%0d overflow error", i);
            if (under_q[i])   $display("tl_handshake_monitor: ch%0d underflow error", i);
            if (timeout_q[i]) $display("tl_handshake_monitor: ch%0d timeout error (%0d cycles)",
                                       i, TIMEOUT);
        end
    end
`endif

endmodule

// File: tb/tb_tl_handshake_monitor.sv
// Directed self-checking bench for tl_handshake_monitor (CHANNELS=2, MAX_OUTSTANDING=8, TIMEOUT=4).
module tb_tl_handshake_monitor;

    localparam int unsigned CH    = 2;
    localparam int unsigned DW    = 32;
    localparam int unsigned CW    = 4;

    logic            clock = 1'b0;
    logic            reset;
    logic [CH-1:0]   a_valid, a_ready, d_valid, d_ready;
    logic [CH*DW-1:0] a_data;
    logic [CH-1:0]   err_stable, err_overflow, err_underflow, err_timeout;
    logic            err_any;
    logic [CH*CW-1:0] outstanding;

    int n_checks = 0;
    int n_errors = 0;

    tl_handshake_monitor #(
        .CHANNELS        (CH),
        .DATA_W          (DW),
        .MAX_OUTSTANDING (8),
        .TIMEOUT         (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .a_valid       (a_valid),
        .a_ready       (a_ready),
        .a_data        (a_data),
        .d_valid       (d_valid),
        .d_ready       (d_ready),
        .err_stable    (err_stable),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow),
        .err_timeout   (err_timeout),
        .err_any       (err_any),
        .outstanding   (outstanding)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        a_valid = '0; a_ready = '0; d_valid = '0; d_ready = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_errs"}, 64'({err_stable, err_overflow, err_underflow, err_timeout}), 64'd0);
    endtask

    int pulses;
    int first_at;
    int t0_seen;

    initial begin
        idle();
        a_data = '0;
        reset  = 1'b0;
        #1 reset = 1'b1;
        #2;
        check("rst_outstanding", 64'(outstanding), 64'd0);
        check("rst_err_any", 64'(err_any), 64'd0);
        check_quiet("rst");
        @(posedge clock);
        #3 reset = 1'b0;

        // Three A-fires then two D-fires on ch0
        a_valid = 2'b01; a_ready = 2'b01;
        tick(); check("fill1", 64'(outstanding[3:0]), 64'd1);
        tick(); check("fill2", 64'(outstanding[3:0]), 64'd2);
        tick(); check("fill3", 64'(outstanding[3:0]), 64'd3);
        idle(); d_valid = 2'b01; d_ready = 2'b01;
        tick(); check("drain1", 64'(outstanding[3:0]), 64'd2);
        tick(); check("drain2", 64'(outstanding[3:0]), 64'd1);
        check("ch1_zero", 64'(outstanding[7:4]), 64'd0);
        idle();
        tick(); check_quiet("basic"); check("basic_any", 64'(err_any), 64'd0);

        // Underflow on ch1
        d_valid = 2'b10; d_ready = 2'b10;
        tick();
        check("under_pulse", 64'(err_underflow), 64'h2);
        check("under_cnt", 64'(outstanding[7:4]), 64'd0);
        check("under_any_lag", 64'(err_any), 64'd0);
        idle();
        tick();
        check("under_clear", 64'(err_underflow), 64'd0);
        check("under_any", 64'(err_any), 64'd1);
        tick(); check("any_sticky", 64'(err_any), 64'd1);
        do_reset();
        check("any_reset", 64'(err_any), 64'd0);

        // Overflow on ch0, then same-cycle A+D at the limit
        a_valid = 2'b01; a_ready = 2'b01;
        for (int k = 0; k < 8; k++) tick();
        check("ovf_full", 64'(outstanding[3:0]), 64'd8);
        check("ovf_none_yet", 64'(err_overflow), 64'd0);
        tick();
        check("ovf_pulse", 64'(err_overflow), 64'h1);
        check("ovf_hold", 64'(outstanding[3:0]), 64'd8);
        d_valid = 2'b01; d_ready = 2'b01;
        tick();
        check("ovf_ad_none", 64'(err_overflow), 64'd0);
        check("ovf_ad_cnt", 64'(outstanding[3:0]), 64'd8);
        do_reset();

        // Payload change during stall, then valid drop during stall
        a_valid = 2'b01; a_ready = 2'b00; a_data[31:0] = 32'hDEADBEEF;
        tick(); check("stab_first", 64'(err_stable), 64'd0);
        a_data[31:0] = 32'hDEADBEE0;
        tick(); check("stab_change", 64'(err_stable), 64'h1);
        a_ready = 2'b01;
        tick(); check("stab_fire", 64'(err_stable), 64'd0);
        check("stab_cnt", 64'(outstanding[3:0]), 64'd1);
        a_ready = 2'b00; a_data[31:0] = 32'h1234_5678;
        tick(); check("stab_stall2", 64'(err_stable), 64'd0);
        a_valid = 2'b00;
        tick(); check("stab_drop", 64'(err_stable), 64'h1);
        tick(); check("stab_drop_clear", 64'(err_stable), 64'd0);
        do_reset();

        // ch1 stalled for ten cycles
        pulses = 0; first_at = 0; t0_seen = 0;
        a_valid = 2'b10; a_ready = 2'b00; a_data[63:32] = 32'hCAFE_0001;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (err_timeout[1]) begin
                pulses++;
                if (first_at == 0) first_at = k;
            end
            if (err_timeout[0]) t0_seen++;
        end
        check("to_ch0", 64'(t0_seen), 64'd0);
        check("to_stable", 64'(err_stable), 64'd0);
`ifdef TL_HANDSHAKE_MONITOR_TIMEOUT_EN
        check("to_pulses", 64'(pulses), 64'd1);
        check("to_when", 64'(first_at), 64'd4);
        check("to_any", 64'(err_any), 64'd1);
`else
        check("to_pulses", 64'(pulses), 64'd0);
        check("to_any", 64'(err_any), 64'd0);
`endif
        a_ready = 2'b10;
        tick(); check("to_fire_stable", 64'(err_stable), 64'd0);
        check("to_fire_cnt", 64'(outstanding[7:4]), 64'd1);
        do_reset();

        // Reset mid-cycle with count 3 and err_any set
        a_valid = 2'b01; a_ready = 2'b01;
        tick(); tick(); tick();
        idle(); d_valid = 2'b10; d_ready = 2'b10;
        tick();
        idle();
        tick();
        check("mid_cnt", 64'(outstanding[3:0]), 64'd3);
        check("mid_any", 64'(err_any), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_out", 64'(outstanding), 64'd0);
        check("mid_rst_any", 64'(err_any), 64'd0);
        check_quiet("mid_rst");
        #1 reset = 1'b0;
        d_valid = 2'b01; d_ready = 2'b01;
        tick();
        check("post_rst_under", 64'(err_underflow), 64'h1);
        check("post_rst_cnt", 64'(outstanding[3:0]), 64'd0);
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
